branch_predictor: RTL
=====================

# branch_predictor

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters for the pipelined RV32 core. It gives the fetch stage a same-cycle next-PC prediction and is trained by the stage that resolves control flow, which is MEM in the current pipeline. It replaces the fixed PC+4 next-PC policy with predicted fetch plus mispredict redirect. It also keeps saturating performance counters for branch accuracy.

## Interface
- ENTRIES, 16, number of BTB entries; power of two, 2..1024; IDX = log2(ENTRIES)
- XLEN, 32, PC/target width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- pc_if  in  XLEN  fetch-stage PC being looked up
- pred_hit  out  1  valid entry whose tag matches pc_if
- pred_taken  out  1  predicted taken
- pred_target  out  XLEN  predicted next PC
- upd_valid  in  1  a resolved control-flow instruction is presented this cycle
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_is_jump  in  1  1 = JAL/JALR (always taken), 0 = conditional branch
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual taken target
- upd_pred_taken  in  1  prediction made for this instruction, carried down the pipe
- upd_pred_target  in  XLEN  predicted next PC, carried down the pipe
- inv_all  in  1  synchronous invalidate of every entry (fence.i / context switch)
- mispredict  out  1  redirect fetch and flush younger stages
- redirect_pc  out  XLEN  correct next PC when mispredict = 1
- br_cnt  out  32  count of upd_valid cycles
- mp_cnt  out  32  count of mispredict cycles

## Operation
- Entry fields: valid, tag = pc[XLEN-1:IDX+2], target[XLEN-1:0], ctr[1:0], jmp.
- Index: pc[IDX+1:2]. pc[1:0] is ignored.
- Lookup (combinational from pc_if and current table):
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & (jmp | ctr[1]).
  - pred_target = pred_taken ? target : pc_if + 4, with modulo-2^XLEN wrap.
- Update, on the clock edge when upd_valid = 1, at index from upd_pc:
  - Hit, conditional branch: ctr increments on taken and saturates at 3; ctr decrements on not-taken and saturates at 0. If taken, target <= upd_target. jmp <= 0.
  - Hit, jump: jmp <= 1, target <= upd_target, ctr <= 3.
  - Miss, taken: allocate by overwriting the slot. valid=1, new tag, target=upd_target, jmp=upd_is_jump, ctr = jump ? 3 : 2 (weakly taken).
  - Miss, not taken: no allocation, table unchanged.
- mispredict (combinational) = upd_valid & (actual_next != upd_pred_target).
  - actual_next = upd_taken ? upd_target : upd_pc + 4.
  - redirect_pc = actual_next whenever upd_valid, else 0.
- Counters: br_cnt +1 per upd_valid cycle; mp_cnt +1 per mispredict cycle. Both saturate at 32'hFFFF_FFFF. Only rst clears them.
- inv_all clears every valid bit at the edge. Other fields are don't-care.

## Timing
- Lookup latency 0 cycles, since pc_if to pred_* is combinational. Update takes effect from the cycle after the edge.
- Same index looked up and updated in the same cycle: lookup returns the pre-update contents. There is no write-through bypass.
- inv_all and upd_valid in the same cycle: invalidate wins and no allocation occurs. The counters still count the update.
- Reset (rst = 0, asynchronous, takes effect mid-cycle):
  - All valid = 0 and counters = 0.
  - Outputs become pred_hit = 0, pred_taken = 0, pred_target = pc_if + 4.
  - mispredict follows its inputs. It is a function of the upd_* signals only, not of the table.
- Release of rst is synchronised by the integrating clock domain. The block applies no release filtering.
- pc_if = 32'hFFFF_FFFC with no hit gives pred_target = 32'h0000_0000.

## Test plan
- Reset then lookup pc_if = 0x100 -> pred_hit = 0, pred_taken = 0, pred_target = 0x104; br_cnt = mp_cnt = 0.
- Update pc 0x100 as branch, taken, target 0x80, pred_target 0x104 -> mispredict = 1, redirect_pc = 0x80. Next cycle, lookup 0x100 gives hit, taken, target 0x80 (ctr = 2); mp_cnt = 1.
- Same branch trained not-taken twice -> ctr 2→1→0 and lookup predicts 0x104. A third not-taken leaves ctr at 0. One taken brings ctr to 1 and the prediction stays not-taken.
- Aliasing with ENTRIES = 16: allocate 0x100 (taken), then 0x140 (taken, target 0x200) -> lookup 0x100 misses and lookup 0x140 hits with 0x200. Not-taken at 0x180 on a miss does not allocate.
- Jump at 0x10 to 0x400 -> jmp entry, always taken. inv_all in the same cycle as an update at 0x20 -> afterwards both 0x10 and 0x20 miss; br_cnt has counted both updates.
- Reset asserted mid-sequence with entries valid and counters non-zero -> immediate pred_hit = 0 and br_cnt = mp_cnt = 0 without a clock edge.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped BTB with 2-bit direction counters, mispredict
//            detection and saturating branch/mispredict performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_if,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    input  logic            inv_all,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     br_cnt,
    output logic [31:0]     mp_cnt
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = XLEN - IDX - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [TW-1:0]      r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic               r_jmp    [ENTRIES];
    logic [31:0]        r_br_cnt;
    logic [31:0]        r_mp_cnt;

    logic [IDX-1:0]     w_lk_idx;
    logic [TW-1:0]      w_lk_tag;
    logic [XLEN-1:0]    w_lk_seq;
    logic [IDX-1:0]     w_up_idx;
    logic [TW-1:0]      w_up_tag;
    logic               w_up_hit;
    logic [XLEN-1:0]    w_actual_next;
    logic               w_unused;

    // The prediction flag travels with the instruction for debug only;
    // redirect decisions compare next-PC values directly.
    assign w_unused = &{1'b0, pc_if[1:0], upd_pc[1:0], upd_pred_taken};

    // Fetch-side lookup
    assign w_lk_idx    = pc_if[IDX+1:2];
    assign w_lk_tag    = pc_if[XLEN-1:IDX+2];
    assign w_lk_seq    = pc_if + XLEN'(4);
    assign pred_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken  = pred_hit && (r_jmp[w_lk_idx] || r_ctr[w_lk_idx][1]);
    assign pred_target = pred_taken ? r_target[w_lk_idx] : w_lk_seq;

    // Resolve-side check
    assign w_up_idx      = upd_pc[IDX+1:2];
    assign w_up_tag      = upd_pc[XLEN-1:IDX+2];
    assign w_up_hit      = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_actual_next = upd_taken ? upd_target : (upd_pc + XLEN'(4));
    assign mispredict    = upd_valid && (w_actual_next != upd_pred_target);
    assign redirect_pc   = upd_valid ? w_actual_next : '0;

    assign br_cnt = r_br_cnt;
    assign mp_cnt = r_mp_cnt;

    // Valid bits and performance counters carry the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= '0;
            r_br_cnt <= '0;
            r_mp_cnt <= '0;
        end else begin
            if (inv_all) begin
                r_valid <= '0;
            end else if (upd_valid && !w_up_hit && upd_taken) begin
                r_valid[w_up_idx] <= 1'b1;
            end
            if (upd_valid && (r_br_cnt != 32'hFFFF_FFFF)) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
            if (mispredict && (r_mp_cnt != 32'hFFFF_FFFF)) begin
                r_mp_cnt <= r_mp_cnt + 32'd1;
            end
        end
    end

    // Payload fields are only meaningful while valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (upd_valid && !inv_all) begin
            if (w_up_hit) begin
                if (upd_is_jump) begin
                    r_jmp[w_up_idx]    <= 1'b1;
                    r_target[w_up_idx] <= upd_target;
                    r_ctr[w_up_idx]    <= 2'd3;
                end else begin
                    r_jmp[w_up_idx] <= 1'b0;
                    if (upd_taken) begin
                        r_target[w_up_idx] <= upd_target;
                        if (r_ctr[w_up_idx] != 2'd3) begin
                            r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
                        end
                    end else if (r_ctr[w_up_idx] != 2'd0) begin
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
                    end
                end
            end else if (upd_taken) begin
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= upd_target;
                r_jmp[w_up_idx]    <= upd_is_jump;
                r_ctr[w_up_idx]    <= upd_is_jump ? 2'd3 : 2'd2;
            end
        end
    end

endmodule
`default_nettype wire
